// File: rtl/stall_pipe_pkg.sv
// Shared defaults and operand triple type for the operand issue queue and its users.
package stall_pipe_pkg;

   localparam int W_DEF     = 16;
   localparam int DEPTH_DEF = 4;

   typedef struct packed {
      logic [W_DEF-1:0] a;
      logic [W_DEF-1:0] b;
      logic [W_DEF-1:0] c;
   } operand_t;

endpackage

// File: rtl/operand_issue_q_if.sv
// Upstream push handshake and downstream stall-pipeline view of the operand issue queue.
// Handshake: a triple transfers on a rising edge where in_valid && in_ready; in_ready
// never depends on in_valid or hold. Downstream consumes the head on every edge where !stall.
interface operand_issue_q_if
   import stall_pipe_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int DEPTH = DEPTH_DEF
);

   logic                   in_valid;
   logic                   in_ready;
   logic [W-1:0]           in_a;
   logic [W-1:0]           in_b;
   logic [W-1:0]           in_c;
   logic                   hold;
   logic [W-1:0]           a;
   logic [W-1:0]           b;
   logic [W-1:0]           c;
   logic                   stall;
   logic [$clog2(DEPTH):0] count;

   modport master (
      output in_valid, in_a, in_b, in_c, hold,
      input  in_ready, a, b, c, stall, count
   );

   modport slave (
      input  in_valid, in_a, in_b, in_c, hold,
      output in_ready, a, b, c, stall, count
   );

endinterface

// File: rtl/operand_issue_q.sv
// Circular operand-triple queue feeding a stall pipeline; head shown on a/b/c, zero when empty.
module operand_issue_q
   import stall_pipe_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input logic               clk,
   input logic               rst_n,
   operand_issue_q_if.slave  bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count_q;
   logic            empty;
   logic            in_ready;
   logic            stall;
   logic            push;
   logic            pop;
   entry_t          head;

   assign empty    = (count_q == '0);
   assign in_ready = (count_q < CW'(DEPTH));
   assign stall    = empty || bus.hold;
   assign push     = bus.in_valid && in_ready;
   assign pop      = !stall;

   // Storage is deliberately not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, c: bus.in_c};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      head = '0;
      if (!empty) head = mem[rd_ptr];
   end

   assign bus.in_ready = in_ready;
   assign bus.stall    = stall;
   assign bus.count    = count_q;
   assign bus.a        = head.a;
   assign bus.b        = head.b;
   assign bus.c        = head.c;

   always @(posedge clk) begin
      if (rst_n) begin
         assert (count_q <= CW'(DEPTH)) else $error("occupancy above DEPTH");
         assert (!empty || stall) else $error("empty queue not stalling");
         assert (in_ready == (count_q < CW'(DEPTH))) else $error("in_ready inconsistent");
         assert (!empty || (head == '0)) else $error("outputs nonzero while empty");
      end
   end

endmodule

// File: tb/tb_operand_issue_q.sv
// Randomized and directed bench for operand_issue_q against a queue-based reference model.
module tb_operand_issue_q;
   import stall_pipe_pkg::*;

   localparam int W     = W_DEF;
   localparam int DEPTH = DEPTH_DEF;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   operand_t exp_q[$];

   operand_issue_q_if #(.W(W), .DEPTH(DEPTH)) bus ();

   operand_issue_q #(.W(W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Compare every output against what the queue model says it should be right now.
   task automatic check_outputs(input string tag);
      operand_t h;
      int n;
      n = exp_q.size();
      h = (n > 0) ? exp_q[0] : '0;
      check({tag, ".count"}, 32'(bus.count), 32'(n));
      check({tag, ".ready"}, 32'(bus.in_ready), 32'(n < DEPTH));
      check({tag, ".stall"}, 32'(bus.stall), 32'((n == 0) || bus.hold));
      check({tag, ".a"}, 32'(bus.a), 32'(h.a));
      check({tag, ".b"}, 32'(bus.b), 32'(h.b));
      check({tag, ".c"}, 32'(bus.c), 32'(h.c));
   endtask

   // Called at a falling edge: drive, check, take the rising edge, update model, return at next falling edge.
   task automatic step(input string tag, input logic v, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [W-1:0] ic, input logic h);
      bit do_pop, do_push;
      operand_t t;
      bus.in_valid = v;
      bus.in_a     = ia;
      bus.in_b     = ib;
      bus.in_c     = ic;
      bus.hold     = h;
      #1;
      check_outputs(tag);
      do_pop  = (exp_q.size() > 0) && !h;
      do_push = v && (exp_q.size() < DEPTH);
      t = '{a: ia, b: ib, c: ic};
      @(posedge clk);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(t);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_c     = '0;
      bus.hold     = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs("reset_low");
      rst_n = 1'b1;
      step("reset_idle", 1'b0, 0, 0, 0, 1'b0);

      // single push then drain
      step("single_push", 1'b1, 1, 2, 3, 1'b0);
      check("single_a", 32'(bus.a), 32'd1);
      step("single_head", 1'b0, 0, 0, 0, 1'b0);
      step("single_empty", 1'b0, 0, 0, 0, 1'b0);

      // fill under hold, drop the fifth, drain in order
      for (int i = 1; i <= 5; i++)
         step("fill", 1'b1, W'(i * 10), W'(i * 10 + 1), W'(i * 10 + 2), 1'b1);
      check("fill_count", 32'(bus.count), 32'(DEPTH));
      for (int i = 0; i < DEPTH + 1; i++)
         step("drain", 1'b0, 0, 0, 0, 1'b0);

      // concurrent push/pop at occupancy 2
      step("conc_pre", 1'b1, 7, 8, 9, 1'b1);
      step("conc_pre", 1'b1, 17, 18, 19, 1'b1);
      for (int i = 0; i < 6; i++)
         step("conc", 1'b1, W'(100 + i), W'(i), W'(i), 1'b0);
      check("conc_count", 32'(bus.count), 32'd2);
      for (int i = 0; i < 3; i++)
         step("conc_drain", 1'b0, 0, 0, 0, 1'b0);

      // pointer wrap with sequential push/pop
      for (int i = 0; i < 3 * DEPTH; i++) begin
         step("wrap_push", 1'b1, W'(i), W'(i + 1), W'(i + 2), 1'b1);
         step("wrap_pop", 1'b0, 0, 0, 0, 1'b0);
      end

      // asynchronous reset mid-operation
      for (int i = 0; i < 3; i++)
         step("pre_rst", 1'b1, W'(200 + i), W'(300 + i), W'(400 + i), 1'b1);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("midrst_count", 32'(bus.count), 32'd0);
      check_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_push", 1'b1, 16'hABCD, 16'h1234, 16'h5678, 1'b1);
      check("post_rst_count", 32'(bus.count), 32'd1);
      step("post_rst_pop", 1'b0, 0, 0, 0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step("rand", ($urandom_range(0, 9) < 7), W'($urandom), W'($urandom), W'($urandom),
              ($urandom_range(0, 9) < 3));
      for (int i = 0; i < DEPTH + 1; i++)
         step("rand_drain", 1'b0, 0, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/operand_issue_q.md
OPERAND_ISSUE_Q -- requirements
Module: operand_issue_q

Interface
REQ-001 Parameter W SHALL be: W, default 16, operand width in bits.
REQ-002 Parameter DEPTH SHALL be: DEPTH, default 4, queue entries (power of two, >= 2).
REQ-003 Port clk SHALL be: clk  input  1  single clock, all state on rising edge.
REQ-004 Port rst_n SHALL be: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid SHALL be: in_valid  input  1  upstream offers an operand triple.
REQ-006 Port in_ready SHALL be: in_ready  output  1  queue accepts the triple this cycle.
REQ-007 Ports in_a, in_b, in_c SHALL be: in_a/in_b/in_c  input  W  operand triple.
REQ-008 Port hold SHALL be: hold  input  1  downstream back-pressure request.
REQ-009 Ports a, b, c SHALL be: a/b/c  output  W  head triple presented to the downstream stall pipeline.
REQ-010 Port stall SHALL be: stall  output  1  downstream must not advance this cycle.
REQ-011 Port count SHALL be: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-012 Push SHALL occur on a clock edge where in_valid && in_ready, writing {in_a,in_b,in_c} at the write pointer.
REQ-013 in_ready SHALL equal (count < DEPTH), combinationally, independent of hold and of a same-cycle pop; no full-queue bypass.
REQ-014 stall SHALL equal (count == 0) || hold, combinationally.
REQ-015 Pop SHALL occur on a clock edge where !stall; the read pointer advances by one.
REQ-016 a/b/c SHALL show the head entry when count > 0 and all-zero when count == 0.
REQ-017 Latency SHALL be: a triple pushed at edge N appears on a/b/c from cycle N+1 at the earliest; no same-cycle empty bypass.
REQ-018 Order SHALL be strict FIFO; each accepted triple is presented exactly once and is consumed by exactly one pop.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL never exceed DEPTH nor underflow.
REQ-021 in_valid while !in_ready SHALL have no effect on state; data is not captured.
REQ-022 A change in hold SHALL affect stall in the same cycle and SHALL NOT alter queue contents.
REQ-023 Operand values SHALL be stored unmodified; no arithmetic on data.
REQ-024 Embedded immediate assertions (checked while rst_n high) SHALL state: count <= DEPTH; stall when count == 0; in_ready == (count < DEPTH); a/b/c zero when count == 0.

Reset
REQ-025 While rst_n is low: count = 0, both pointers = 0, in_ready = 1, stall = 1, a/b/c = 0.
REQ-026 Reset asserted mid-operation SHALL discard all entries immediately; storage contents need not be cleared.
REQ-027 After rst_n deasserts, the first push SHALL be accepted on the first rising edge.

Structure
REQ-028 Shared package stall_pipe_pkg SHALL hold the W default, the DEPTH default, and typedef operand_t (packed struct a,b,c).
REQ-029 Storage, pointers and count SHALL be implemented inline; no sub-module.

Verification
REQ-030 Reset: rst_n low, then high; in_valid=0 -> count=0, stall=1, in_ready=1, a=b=c=0.
REQ-031 Single push: push (1,2,3) with hold=0 -> next cycle a=1,b=2,c=3, stall=0; following cycle count=0, stall=1.
REQ-032 Fill: hold=1, push (10,11,12),(20,21,22),(30,31,32),(40,41,42) -> count=4, in_ready=0; a 5th offer (50,51,52) is dropped; release hold -> outputs in push order over 4 cycles; the 5th triple never appears.
REQ-033 Concurrent: count=2, in_valid=1, hold=0 for 6 cycles with values 100..105 in a -> count stays 2; a sequence is the two old heads, then 100,101,...
REQ-034 Wrap: 3*DEPTH sequential push/pop with a=i, b=i+1, c=i+2 -> order preserved through pointer wrap; no assertion fires.
REQ-035 Mid-op reset: count=3, pull rst_n low asynchronously between edges -> count=0, stall=1, a/b/c=0 before the next edge.
